fpu_pipe_core: RTL and testbench

- Multi-cycle IEEE-754 binary floating-point unit, generalised over bitness, for the processor's FP execution slot.
- Supports add, sub and mul.
- Implements full special-case handling, leading-zero normalisation, round-to-nearest-even and exception flags.
- Uses the same rdy/ack operand and result handshake as the existing FPU, so it drops into the same slot.

---
 rtl/fpu_pipe_core.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_fpu_pipe_core.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fpu_pipe_core.sv
// fpu_pipe_core: multi-cycle IEEE-754 add/sub/mul with rdy/ack handshakes, RNE rounding and flags.
// Define FPU_SUBNORMAL_EN for gradual underflow; without it, subnormal inputs and tiny results flush to zero.
`default_nettype none

module fpu_pipe_core #(
   parameter int bitness = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               input_rdy,
   output logic               input_ack,
   output logic               output_rdy,
   input  logic               output_ack,
   input  logic [bitness-1:0] data_a,
   input  logic [bitness-1:0] data_b,
   input  logic [3:0]         command,
   output logic [bitness-1:0] result,
   output logic [3:0]         flags
);

   localparam int EXP_W  = (bitness == 16) ? 5  : (bitness == 32) ? 8  : (bitness == 64) ? 11 : 15;
   localparam int MANT_W = (bitness == 16) ? 10 : (bitness == 32) ? 23 : (bitness == 64) ? 52 : 112;
   localparam int F_W    = MANT_W + 4;
   localparam int XW     = EXP_W + 2;
   localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
   localparam logic signed [XW-1:0] BIAS_S = XW'(BIAS);
   localparam logic signed [XW-1:0] EMAX_S = XW'((1 << EXP_W) - 1);
   localparam logic signed [XW-1:0] ONE_S  = XW'(1);
   localparam logic [XW-1:0]        DMAX   = XW'(MANT_W + 3);
   localparam logic [bitness-1:0]   QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

   if (!(bitness == 16 || bitness == 32 || bitness == 64 || bitness == 128)) begin : g_bad_bitness
      $error("fpu_pipe_core: bitness must be 16, 32, 64 or 128");
   end

   typedef enum logic [3:0] {
      GET_INPUT, UNPACK, SPECIAL, ALIGN, OP, NORMALIZE, ROUND, PACK, PUT_RESULT
   } state_t;

   state_t state;

   logic [bitness-1:0]   a_r, b_r;
   logic [3:0]           cmd_r;
   logic                 sa, sb, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b, zero_a, zero_b;
   logic signed [XW-1:0] ea, eb, exp_r;
   logic [MANT_W:0]      ma, mb, mant_r;
   logic [F_W-1:0]       big_f, small_f, norm_r;
   logic [F_W:0]         sum_r;
   logic                 sign_big, sign_small, sign_r, zero_r, tiny_r, inexact_r;

   function automatic logic signed [XW-1:0] eff_exp(input logic [EXP_W-1:0] ex);
`ifdef FPU_SUBNORMAL_EN
      return (ex == '0) ? ONE_S : {2'b00, ex};
`else
      return {2'b00, ex};
`endif
   endfunction

   function automatic logic [MANT_W:0] eff_man(input logic [EXP_W-1:0] ex, input logic [MANT_W-1:0] fr);
`ifdef FPU_SUBNORMAL_EN
      return {ex != '0, fr};
`else
      return (ex != '0) ? {1'b1, fr} : '0;
`endif
   endfunction

   function automatic logic is_zero(input logic [EXP_W-1:0] ex, input logic [MANT_W-1:0] fr);
`ifdef FPU_SUBNORMAL_EN
      return (ex == '0) && (fr == '0);
`else
      return (ex == '0) && (fr == fr);
`endif
   endfunction

   function automatic logic signed [XW-1:0] lzc(input logic [F_W-1:0] v);
      logic signed [XW-1:0] n;
      logic                 found;
      n     = XW'(F_W);
      found = 1'b0;
      for (int i = F_W - 1; i >= 0; i--) begin
         if (!found && v[i]) begin
            n     = XW'(F_W - 1 - i);
            found = 1'b1;
         end
      end
      return n;
   endfunction

   // Special-case detection, in priority order
   logic               sp_hit, sp_inv, is_mul;
   logic [bitness-1:0] sp_res;
   always_comb begin
      is_mul = (cmd_r == 4'd2);
      sp_hit = 1'b1;
      sp_inv = 1'b0;
      sp_res = QNAN;
      if (cmd_r > 4'd2) begin
         sp_inv = 1'b1;
      end else if (nan_a || nan_b) begin
         sp_inv = snan_a || snan_b;
      end else if (!is_mul && inf_a && inf_b && (sa != sb)) begin
         sp_inv = 1'b1;
      end else if (is_mul && ((inf_a && zero_b) || (inf_b && zero_a))) begin
         sp_inv = 1'b1;
      end else if (inf_a || inf_b) begin
         sp_res = {(is_mul ? (sa ^ sb) : (inf_a ? sa : sb)), {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      end else if (is_mul && (zero_a || zero_b)) begin
         sp_res = {sa ^ sb, {(bitness-1){1'b0}}};
      end else begin
         sp_hit = 1'b0;
      end
   end

   logic                 al_swap;
   logic signed [XW-1:0] al_exp;
   logic [XW-1:0]        al_diff;
   logic [MANT_W:0]      al_small_m;
   logic [F_W-1:0]       al_big, al_small, al_ext, al_lost;
   always_comb begin
      al_swap    = (eb > ea);
      al_exp     = al_swap ? eb : ea;
      al_diff    = al_swap ? (eb - ea) : (ea - eb);
      al_small_m = al_swap ? ma : mb;
      al_big     = {(al_swap ? mb : ma), 3'b000};
      al_ext     = {al_small_m, 3'b000};
      al_lost    = al_ext & ~({F_W{1'b1}} << al_diff);
      if (al_diff >= DMAX)
         al_small = {{(F_W-1){1'b0}}, |al_small_m};
      else
         al_small = (al_ext >> al_diff) | {{(F_W-1){1'b0}}, |al_lost};
   end

   logic [2*MANT_W+1:0]  op_prod;
   logic [F_W:0]         op_sum;
   logic signed [XW-1:0] op_exp;
   logic                 op_sign, op_zero, op_eff_sub;
   always_comb begin
      op_prod    = ma * mb;
      op_sum     = '0;
      op_exp     = exp_r;
      op_sign    = sign_big;
      op_zero    = 1'b0;
      op_eff_sub = sign_big ^ sign_small;
      if (cmd_r == 4'd2) begin
         op_sum  = {op_prod[2*MANT_W+1:MANT_W-2], |op_prod[MANT_W-3:0]};
         op_exp  = ea + eb - BIAS_S;
         op_sign = sa ^ sb;
      end else begin
         if (!op_eff_sub) begin
            op_sum = {1'b0, big_f} + {1'b0, small_f};
         end else if (big_f >= small_f) begin
            op_sum = {1'b0, big_f} - {1'b0, small_f};
         end else begin
            op_sum  = {1'b0, small_f} - {1'b0, big_f};
            op_sign = sign_small;
         end
         op_zero = (op_sum == '0);
         // An exact cancellation is +0; only (-0)+(-0) keeps the minus sign
         if (op_zero && op_eff_sub)
            op_sign = 1'b0;
      end
   end

   logic signed [XW-1:0] nm_exp, nm_lz;
   logic [F_W-1:0]       nm_val;
   logic                 nm_tiny;
`ifdef FPU_SUBNORMAL_EN
   logic [XW-1:0]        dn_sh;
   logic [F_W-1:0]       dn_lost;
`endif
   always_comb begin
      nm_lz  = '0;
      nm_val = '0;
      nm_exp = exp_r;
      if (sum_r[F_W]) begin
         nm_val = sum_r[F_W:1] | {{(F_W-1){1'b0}}, sum_r[0]};
         nm_exp = exp_r + ONE_S;
      end else begin
         nm_lz  = lzc(sum_r[F_W-1:0]);
         nm_val = sum_r[F_W-1:0] << nm_lz;
         nm_exp = exp_r - nm_lz;
      end
      nm_tiny = (nm_exp < ONE_S);
`ifdef FPU_SUBNORMAL_EN
      dn_sh   = ONE_S - nm_exp;
      dn_lost = nm_val & ~({F_W{1'b1}} << dn_sh);
      if (nm_tiny) begin
         if (dn_sh >= XW'(F_W))
            nm_val = {{(F_W-1){1'b0}}, |nm_val};
         else
            nm_val = (nm_val >> dn_sh) | {{(F_W-1){1'b0}}, |dn_lost};
         nm_exp = ONE_S;
      end
`endif
   end

   logic                 rd_up, rd_inexact;
   logic [MANT_W+1:0]    rd_sum;
   logic [MANT_W:0]      rd_mant;
   logic signed [XW-1:0] rd_exp;
   always_comb begin
      rd_up      = norm_r[2] & (norm_r[1] | norm_r[0] | norm_r[3]);
      rd_sum     = {1'b0, norm_r[F_W-1:3]} + {{(MANT_W+1){1'b0}}, rd_up};
      rd_inexact = |norm_r[2:0];
      if (rd_sum[MANT_W+1]) begin
         rd_mant = rd_sum[MANT_W+1:1];
         rd_exp  = exp_r + ONE_S;
      end else begin
         rd_mant = rd_sum[MANT_W:0];
         rd_exp  = exp_r;
      end
   end

   logic [bitness-1:0] pk_res;
   logic [3:0]         pk_flags;
   always_comb begin
      if (zero_r) begin
         pk_res   = {sign_r, {(bitness-1){1'b0}}};
         pk_flags = 4'b0000;
      end else if (exp_r >= EMAX_S) begin
         pk_res   = {sign_r, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
         pk_flags = 4'b0101;
      end else if (exp_r <= 0) begin
         pk_res   = {sign_r, {(bitness-1){1'b0}}};
         pk_flags = 4'b0011;
      end else begin
         // A clear hidden bit marks a subnormal, whose exponent field is 0
         pk_res   = {sign_r, exp_r[EXP_W-1:0] & {EXP_W{mant_r[MANT_W]}}, mant_r[MANT_W-1:0]};
         pk_flags = {2'b00, tiny_r & inexact_r, inexact_r};
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= GET_INPUT;
         input_ack  <= 1'b0;
         output_rdy <= 1'b0;
         result     <= '0;
         flags      <= '0;
      end else begin
         input_ack <= 1'b0;
         case (state)
            GET_INPUT: if (input_rdy) begin
               a_r       <= data_a;
               b_r       <= data_b;
               cmd_r     <= command;
               input_ack <= 1'b1;
               flags     <= '0;
               state     <= UNPACK;
            end
            UNPACK: begin
               sa     <= a_r[bitness-1];
               sb     <= b_r[bitness-1] ^ (cmd_r == 4'd1);
               ea     <= eff_exp(a_r[bitness-2:MANT_W]);
               eb     <= eff_exp(b_r[bitness-2:MANT_W]);
               ma     <= eff_man(a_r[bitness-2:MANT_W], a_r[MANT_W-1:0]);
               mb     <= eff_man(b_r[bitness-2:MANT_W], b_r[MANT_W-1:0]);
               zero_a <= is_zero(a_r[bitness-2:MANT_W], a_r[MANT_W-1:0]);
               zero_b <= is_zero(b_r[bitness-2:MANT_W], b_r[MANT_W-1:0]);
               inf_a  <= (&a_r[bitness-2:MANT_W]) && (a_r[MANT_W-1:0] == '0);
               inf_b  <= (&b_r[bitness-2:MANT_W]) && (b_r[MANT_W-1:0] == '0);
               nan_a  <= (&a_r[bitness-2:MANT_W]) && (a_r[MANT_W-1:0] != '0);
               nan_b  <= (&b_r[bitness-2:MANT_W]) && (b_r[MANT_W-1:0] != '0);
               snan_a <= (&a_r[bitness-2:MANT_W]) && (a_r[MANT_W-1:0] != '0) && !a_r[MANT_W-1];
               snan_b <= (&b_r[bitness-2:MANT_W]) && (b_r[MANT_W-1:0] != '0) && !b_r[MANT_W-1];
               state  <= SPECIAL;
            end
            SPECIAL: if (sp_hit) begin
               result     <= sp_res;
               flags      <= {sp_inv, 3'b000};
               output_rdy <= 1'b1;
               state      <= PUT_RESULT;
            end else begin
               state <= ALIGN;
            end
            ALIGN: begin
               if (cmd_r != 4'd2) begin
                  big_f      <= al_big;
                  small_f    <= al_small;
                  exp_r      <= al_exp;
                  sign_big   <= al_swap ? sb : sa;
                  sign_small <= al_swap ? sa : sb;
               end
               state <= OP;
            end
            OP: begin
               sum_r  <= op_sum;
               exp_r  <= op_exp;
               sign_r <= op_sign;
               zero_r <= op_zero;
               state  <= NORMALIZE;
            end
            NORMALIZE: begin
               norm_r <= nm_val;
               exp_r  <= nm_exp;
               tiny_r <= nm_tiny;
               state  <= ROUND;
            end
            ROUND: begin
               mant_r    <= rd_mant;
               exp_r     <= rd_exp;
               inexact_r <= rd_inexact;
               state     <= PACK;
            end
            PACK: begin
               result     <= pk_res;
               flags      <= pk_flags;
               output_rdy <= 1'b1;
               state      <= PUT_RESULT;
            end
            PUT_RESULT: if (output_ack) begin
               output_rdy <= 1'b0;
               state      <= GET_INPUT;
            end
            default: state <= GET_INPUT;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fpu_pipe_core.sv
// tb_fpu_pipe_core: directed vectors for fpu_pipe_core at bitness 32, plus one add at bitness 64.
`default_nettype none

module tb_fpu_pipe_core;

   logic        clock, reset;
   logic        input_rdy, input_ack, output_rdy, output_ack;
   logic [31:0] data_a, data_b, result;
   logic [3:0]  command, flags;

   logic        rdy64, ack64, ordy64, oack64;
   logic [63:0] a64, b64, res64;
   logic [3:0]  cmd64, flg64;

   int n_cmp = 0;
   int n_bad = 0;

   fpu_pipe_core #(.bitness(32)) dut (
      .clock(clock), .reset(reset),
      .input_rdy(input_rdy), .input_ack(input_ack),
      .output_rdy(output_rdy), .output_ack(output_ack),
      .data_a(data_a), .data_b(data_b), .command(command),
      .result(result), .flags(flags)
   );

   fpu_pipe_core #(.bitness(64)) dut64 (
      .clock(clock), .reset(reset),
      .input_rdy(rdy64), .input_ack(ack64),
      .output_rdy(ordy64), .output_ack(oack64),
      .data_a(a64), .data_b(b64), .command(cmd64),
      .result(res64), .flags(flg64)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] cmd, input logic [31:0] exp_res,
                         input logic [3:0] exp_flg, input int exp_lat, input int hold);
      int lat, extra;
      logic got;
      data_a = a; data_b = b; command = cmd; input_rdy = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clock); #1;
         got = input_ack;
      end
      check_value($sformatf("%s.input_ack", tag), got, 1);
      lat = 0; extra = 0; got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(posedge clock); #1;
         lat++;
         if (input_ack) extra++;
         got = output_rdy;
      end
      input_rdy = 1'b0;
      check_value($sformatf("%s.latency", tag), lat, exp_lat);
      check_value($sformatf("%s.extra_ack", tag), extra, 0);
      check_value($sformatf("%s.result", tag), result, exp_res);
      check_value($sformatf("%s.flags", tag), flags, exp_flg);
      for (int i = 0; i < hold; i++) begin
         @(posedge clock); #1;
         check_value($sformatf("%s.hold_rdy", tag), output_rdy, 1);
         check_value($sformatf("%s.hold_result", tag), result, exp_res);
      end
      output_ack = 1'b1;
      @(posedge clock); #1;
      output_ack = 1'b0;
      check_value($sformatf("%s.rdy_drop", tag), output_rdy, 0);
   endtask

   initial begin
      logic got;
      int   lat;
      reset = 1'b0; input_rdy = 1'b0; output_ack = 1'b0;
      data_a = '0; data_b = '0; command = '0;
      rdy64 = 1'b0; oack64 = 1'b0; a64 = '0; b64 = '0; cmd64 = '0;
      repeat (3) @(posedge clock);
      #1;
      check_value("reset.output_rdy", output_rdy, 0);
      check_value("reset.input_ack", input_ack, 0);
      check_value("reset.result", result, 0);
      check_value("reset.flags", flags, 0);
      check_value("reset.output_rdy64", ordy64, 0);
      reset = 1'b1;
      @(posedge clock); #1;

      run_op("add_1_2",    32'h3F800000, 32'h40000000, 4'b0000, 32'h40400000, 4'b0000, 7, 5);
      run_op("mul_1.5_m2", 32'h3FC00000, 32'hC0000000, 4'b0010, 32'hC0400000, 4'b0000, 7, 0);
      run_op("sub_1_1",    32'h3F800000, 32'h3F800000, 4'b0001, 32'h00000000, 4'b0000, 7, 0);
      run_op("rne_tie",    32'h3F800000, 32'h33800000, 4'b0000, 32'h3F800000, 4'b0001, 7, 0);
      run_op("rne_up",     32'h3F800001, 32'h33800000, 4'b0000, 32'h3F800002, 4'b0001, 7, 0);
      run_op("inf_minf",   32'h7F800000, 32'hFF800000, 4'b0000, 32'h7FC00000, 4'b1000, 2, 0);
      run_op("mul_ovf",    32'h7F7FFFFF, 32'h40000000, 4'b0010, 32'h7F800000, 4'b0101, 7, 0);
      run_op("illegal",    32'h3F800000, 32'h3F800000, 4'b0111, 32'h7FC00000, 4'b1000, 2, 0);
      run_op("snan",       32'h7F800001, 32'h3F800000, 4'b0000, 32'h7FC00000, 4'b1000, 2, 0);
      run_op("qnan",       32'h7FC00001, 32'h3F800000, 4'b0000, 32'h7FC00000, 4'b0000, 2, 0);
      run_op("mul_mzero",  32'h80000000, 32'h3F800000, 4'b0010, 32'h80000000, 4'b0000, 2, 0);
      run_op("mzero_add",  32'h80000000, 32'h80000000, 4'b0000, 32'h80000000, 4'b0000, 7, 0);
`ifdef FPU_SUBNORMAL_EN
      run_op("tiny_mul",   32'h00800000, 32'h3F000000, 4'b0010, 32'h00400000, 4'b0000, 7, 0);
`else
      run_op("tiny_mul",   32'h00800000, 32'h3F000000, 4'b0010, 32'h00000000, 4'b0011, 7, 0);
`endif
      run_op("sub_1_2",    32'h3F800000, 32'h40000000, 4'b0001, 32'hBF800000, 4'b0000, 7, 0);

      // Abort an add while it sits in ALIGN
      data_a = 32'h3F800000; data_b = 32'h40000000; command = 4'b0000; input_rdy = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clock); #1;
         got = input_ack;
      end
      check_value("midreset.input_ack", got, 1);
      input_rdy = 1'b0;
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;
      check_value("midreset.output_rdy", output_rdy, 0);
      check_value("midreset.input_ack", input_ack, 0);
      check_value("midreset.result", result, 0);
      check_value("midreset.flags", flags, 0);
      reset = 1'b1;
      @(posedge clock); #1;
      run_op("add_after_reset", 32'h3F800000, 32'h40000000, 4'b0000, 32'h40400000, 4'b0000, 7, 0);

      a64 = 64'h3FF0000000000000; b64 = 64'h4000000000000000; cmd64 = 4'b0000; rdy64 = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clock); #1;
         got = ack64;
      end
      rdy64 = 1'b0;
      check_value("add64.input_ack", got, 1);
      lat = 0; got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(posedge clock); #1;
         lat++;
         got = ordy64;
      end
      check_value("add64.latency", lat, 7);
      check_value("add64.result", res64, 64'h4008000000000000);
      check_value("add64.flags", flg64, 4'b0000);
      oack64 = 1'b1;
      @(posedge clock); #1;
      oack64 = 1'b0;
      check_value("add64.rdy_drop", ordy64, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
